// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store initiator in front of a
// word-addressed 32-bit data memory without byte enables. Sub-word stores
// are performed as read-modify-write. Load data is lane-selected and
// sign/zero-extended before being returned on the response channel.
//
// Optional feature macro: MEM_ACCESS_SUBWORD_EN
//   defined   : byte and halfword accesses supported
//   undefined : byte/half sizes report an error; stores go straight to WRITE
module mem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state_r, state_next;

  // Request fields latched on the accept edge
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] addr_r;
`ifdef MEM_ACCESS_SUBWORD_EN
  logic        write_r;
  logic [15:0] wdata_r;
`endif

  // Registered outputs and their next values
  logic        resp_valid_r, resp_valid_next;
  logic [31:0] resp_rdata_r, resp_rdata_next;
  logic        resp_error_r, resp_error_next;
  logic        mem_read_r, mem_read_next;
  logic        mem_write_r, mem_write_next;
  logic [31:0] mem_address_r, mem_address_next;
  logic [31:0] mem_write_data_r, mem_write_data_next;

  logic        req_error_s;
  logic [31:0] req_index_s;
  logic [31:0] addr_index_s;

  // Request legality: size, alignment and word-index range
  function automatic logic check_error(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
`ifdef MEM_ACCESS_SUBWORD_EN
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
`endif
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= MEM_WORDS_W) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  // Lane select (little-endian) followed by sign/zero extension
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef MEM_ACCESS_SUBWORD_EN
  // Replace one byte or half lane of the captured word with store data
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'b00:   r[7:0]   = wdata[7:0];
        2'b01:   r[15:8]  = wdata[7:0];
        2'b10:   r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wdata;
    end else begin
      r[15:0] = wdata;
    end
    return r;
  endfunction
`endif

  assign req_error_s  = check_error(req_size, req_addr);
  assign req_index_s  = {2'b00, req_addr[31:2]};
  assign addr_index_s = {2'b00, addr_r[31:2]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Latch request fields when a request is accepted in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      addr_r  <= 32'd0;
`ifdef MEM_ACCESS_SUBWORD_EN
      write_r <= 1'b0;
      wdata_r <= 16'd0;
`endif
    end else if ((state_r == IDLE) && req_valid) begin
      size_r  <= req_size;
      uns_r   <= req_unsigned;
      addr_r  <= req_addr;
`ifdef MEM_ACCESS_SUBWORD_EN
      write_r <= req_write;
      wdata_r <= req_wdata[15:0];
`endif
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_next          = state_r;
    resp_valid_next     = 1'b0;
    resp_rdata_next     = 32'd0;
    resp_error_next     = 1'b0;
    mem_read_next       = 1'b0;
    mem_write_next      = 1'b0;
    mem_address_next    = 32'd0;
    mem_write_data_next = 32'd0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (req_error_s) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_error_next = 1'b1;
          end else if (req_write && (req_size == 2'b10)) begin
            state_next          = WRITE;
            mem_write_next      = 1'b1;
            mem_address_next    = req_index_s;
            mem_write_data_next = req_wdata;
          end else begin
            // loads, and (when enabled) sub-word stores needing the old word
            state_next       = READ;
            mem_read_next    = 1'b1;
            mem_address_next = req_index_s;
          end
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        state_next       = CAPTURE;
        mem_read_next    = 1'b1;
        mem_address_next = addr_index_s;
      end
      CAPTURE: begin
`ifdef MEM_ACCESS_SUBWORD_EN
        if (write_r) begin
          state_next          = WRITE;
          mem_write_next      = 1'b1;
          mem_address_next    = addr_index_s;
          mem_write_data_next = store_merge(mem_read_data, wdata_r, size_r, addr_r[1:0]);
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = load_extract(mem_read_data, size_r, addr_r[1:0], uns_r);
        end
`else
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_extract(mem_read_data, size_r, addr_r[1:0], uns_r);
`endif
      end
      WRITE: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end else begin
          resp_valid_next = 1'b1;
          resp_rdata_next = resp_rdata_r;
          resp_error_next = resp_error_r;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_r     <= 1'b0;
      resp_rdata_r     <= 32'd0;
      resp_error_r     <= 1'b0;
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      mem_address_r    <= 32'd0;
      mem_write_data_r <= 32'd0;
    end else begin
      resp_valid_r     <= resp_valid_next;
      resp_rdata_r     <= resp_rdata_next;
      resp_error_r     <= resp_error_next;
      mem_read_r       <= mem_read_next;
      mem_write_r      <= mem_write_next;
      mem_address_r    <= mem_address_next;
      mem_write_data_r <= mem_write_data_next;
    end
  end

  // Reset kills the memory strobes in the same cycle so an in-flight write never lands
  assign mem_read       = mem_read_r & ~reset;
  assign mem_write      = mem_write_r & ~reset;
  assign mem_address    = reset ? 32'd0 : mem_address_r;
  assign mem_write_data = reset ? 32'd0 : mem_write_data_r;

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_error = resp_error_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard testbench for mem_access_unit: a behavioural memory, a
// reference model of the access rules, directed scenarios then random traffic.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  mem_access_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: synchronous read, synchronous write
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    if (mem_read) mem_read_data <= mem[mem_address[7:0]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit bp_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected response and memory effect of one request
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    logic [31:0] word, mask;
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    bit          bad;
    e.rdata = 32'd0; e.err = 1'b0; e.nrd = 0; e.nwr = 0; e.lat = 1; e.acc = 0;
    bad = (sz == 2'd3) || (!SUB && sz != 2'd2) || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && a[1:0] != 2'd0) || (a[31:2] >= 30'd256);
    if (bad) begin
      e.err = 1'b1;
      return;
    end
    word = ref_mem[a[9:2]];
    sh = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    if (!w) begin
      e.lat = 3; e.nrd = 2;
      b = 8'((word >> sh) & 32'hFF);
      h = 16'((word >> sh) & 32'hFFFF);
      if (sz == 2'd2) e.rdata = word;
      else if (sz == 2'd0) e.rdata = u ? {24'd0, b} : {{24{b[7]}}, b};
      else e.rdata = u ? {16'd0, h} : {{16{h[15]}}, h};
    end else if (sz == 2'd2) begin
      e.lat = 2; e.nwr = 1;
      ref_mem[a[9:2]] = wd;
    end else begin
      e.lat = 4; e.nrd = 2; e.nwr = 1;
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[a[9:2]] = (word & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Present one request, wait for acceptance, then push its expectation
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // later changes must have no effect
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (push) begin
      model(w, sz, u, a, wd, e);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(req_ready && sb.size() == 0 && !resp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic preset(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  // Consumer: random or held-off resp_ready, changed away from the clock edge
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: protocol checks each cycle and scoreboard compare on responses
  int          rd_cnt = 0, wr_cnt = 0;
  bit          seen = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_cnt = 0; wr_cnt = 0; seen = 1'b0;
    end else begin
      chk("strobe_overlap", {31'd0, mem_read & mem_write}, 32'd0);
      if (!mem_read && !mem_write) chk("idle_bus_zero", mem_address | mem_write_data, 32'd0);
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (resp_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("read_cycles", 32'(rd_cnt), 32'(e.nrd));
            chk("write_cycles", 32'(wr_cnt), 32'(e.nwr));
          end
          held_rdata = resp_rdata; held_err = resp_error;
          rd_cnt = 0; wr_cnt = 0;
          seen = 1'b1;
        end else begin
          chk("hold_rdata", resp_rdata, held_rdata);
          chk("hold_error", {31'd0, resp_error}, {31'd0, held_err});
        end
        chk("ready_during_resp", {31'd0, req_ready}, 32'd0);
        if (resp_ready) seen = 1'b0;
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // word store then load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    // sub-word store with read-modify-write
    wait_idle();
    preset(4, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    // load extension
    wait_idle();
    preset(4, 32'h80FF7F01);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);
    // errors
    issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h5A5A0F0F, 1'b1);

    // backpressure: response held for several cycles
    wait_idle();
    bp_hold = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    repeat (8) @(negedge clk);
    bp_hold = 1'b0;

    // reset during the WRITE of a store: no write lands, no response
    wait_idle();
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    #1;
    chk("abort_in_write", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // random traffic, mostly in range, all sizes and alignments
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b1);
    end

    wait_idle();
    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the datapath and the word-addressed data memory (256 × 32-bit, ports address / writeData / memWrite / memRead / readData). It accepts one byte-addressed load or store request at a time through a valid/ready handshake. It sequences the memory control strobes, performing read-modify-write for sub-word stores because the memory has no byte enables. It returns load data (sign- or zero-extended) or an error through a valid/ready response channel.

## Interface
- MEM_WORDS, 256, number of 32-bit words in data memory; word index must be < MEM_WORDS
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, illegal size, or out-of-range
- mem_address  out  32  word index = req_addr[31:2]
- mem_write_data  out  32  word written to memory
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read enable
- mem_read_data  in  32  memory read data

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields and check them:
  - error if size=11;
  - error if half with addr[0]=1, or word with addr[1:0]≠0;
  - error if addr[31:2] ≥ MEM_WORDS.
  - Error → RESP with resp_error=1; no memory strobe is issued.
- Load → READ. Word store → WRITE. Sub-word store → READ.
- READ: mem_read=1, mem_address=latched index → CAPTURE.
- CAPTURE: mem_read=1; latch mem_read_data at the end of the cycle.
  - Load → RESP.
  - Sub-word store → WRITE.
- WRITE: mem_write=1 for exactly one cycle; mem_write_data and mem_address stable for the whole cycle → RESP.
  - Word store: mem_write_data = req_wdata.
  - Sub-word store: captured word with lane replaced. Byte lane = addr[1:0] (little-endian, lane 0 = bits 7:0); half lane = addr[1] (0 → bits 15:0).
- Load extraction: select the lane as above, then sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- RESP: resp_valid=1; outputs held stable until resp_ready. On resp_valid & resp_ready → IDLE.
- mem_read and mem_write are never high in the same cycle. Both are 0 in IDLE and RESP.
- mem_address and mem_write_data read 0 whenever no strobe is active.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Reset mid-transaction aborts immediately: a pending mem_write is dropped and no response is produced.
- Request accepted at edge 0. resp_valid first high:
  - load: cycle 3;
  - word store: cycle 2;
  - sub-word store: cycle 4;
  - error: cycle 1.
- Back-to-back: the next req_ready is high in the cycle after the response handshake. Minimum spacing between accepts is latency + 1.
- Backpressure: resp_ready low holds RESP indefinitely; req_ready stays 0.
- req_* are sampled only on the accept edge; later changes have no effect.

## Configuration
- MEM_ACCESS_SUBWORD_EN defined: byte and half accesses supported as above.
- Undefined: size 00/01 is treated as illegal (resp_error=1, no strobe), and the READ-before-WRITE path for stores is removed. Word behaviour and all timing are unchanged.

## Test plan
- Word store then load: SW addr 0x10 data 0xDEADBEEF → mem_write one cycle with mem_address=4; then LW 0x10 → resp_rdata 0xDEADBEEF on cycle 3, resp_error 0.
- Sub-word store: word 4 = 0x11223344; SB addr 0x12 data 0xAA → exactly one READ/CAPTURE then one write of 0x11AA3344.
- Load extension: word 4 = 0x80FF7F01.
  - LB 0x13 signed → 0xFFFFFF80; LBU 0x13 → 0x00000080.
  - LH 0x10 signed → 0x00007F01; LH 0x12 signed → 0xFFFF80FF.
- Errors, each giving resp_error=1 on cycle 1 with mem_read and mem_write never asserted:
  - LW 0x11;
  - LH 0x13;
  - size 11;
  - LW 0x400 (index 256).
- Backpressure and reset: hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready 0. Assert reset during WRITE of a second transaction → outputs return to reset values next cycle and no response is produced.
- With MEM_ACCESS_SUBWORD_EN undefined: SB 0x12 → resp_error=1, no strobes; SW/LW behave identically to scenario 1.
